// File: rtl/div3_serial_tx.sv
// div3_serial_tx: MSB-first serialiser that streams mod-3 long-division quotient bits and the final remainder.
module div3_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             q_o,
  output logic             div_o,
  output logic             last_o,
  output logic [1:0]       rem_o,
  output logic             done_o
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [1:0] acc, acc_n;
  logic [2:0] t;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && valid_i) state_n = SHIFT;
    if (state == SHIFT && last_o) state_n = IDLE;
  end
  // t is the running prefix remainder doubled plus the bit on the wire
  assign t         = {acc, x_o};
  assign acc_n     = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  assign ready_o   = state == IDLE;
  assign x_valid_o = state == SHIFT;
  assign x_o       = x_valid_o & shreg[WIDTH-1];
  assign last_o    = x_valid_o && cnt == '0;
  assign q_o       = t >= 3'd3;
  assign div_o     = acc_n == 2'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      cnt    <= '0;
      acc    <= '0;
      rem_o  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= last_o;
      if (state == IDLE && valid_i) begin
        shreg <= data_i;
        cnt   <= CW'(WIDTH - 1);
        acc   <= '0;
      end else if (state == SHIFT) begin
        shreg <= shreg << 1;
        cnt   <= cnt - 1'b1;
        acc   <= acc_n;
        if (last_o) rem_o <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_div3_serial_tx.sv
// tb_div3_serial_tx: directed table, corner sequences and random words checked against an arithmetic model.
module tb_div3_serial_tx;
  localparam int W = 8;
  logic clk = 0, reset = 0, valid_i = 0;
  logic [W-1:0] data_i = '0;
  logic ready_o, x_o, x_valid_o, q_o, div_o, last_o, done_o;
  logic [1:0] rem_o;
  int n_cmp = 0, n_bad = 0;

  div3_serial_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_o(x_o), .x_valid_o(x_valid_o), .q_o(q_o), .div_o(div_o), .last_o(last_o),
    .rem_o(rem_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] x;
    logic [W-1:0] q;
    logic [W-1:0] dv;
    logic [1:0]   rem;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, " ready"}, {7'b0, ready_o}, 8'd1);
    chk({tag, " x"}, {7'b0, x_o}, 8'd0);
    chk({tag, " x_valid"}, {7'b0, x_valid_o}, 8'd0);
    chk({tag, " last"}, {7'b0, last_o}, 8'd0);
    chk({tag, " rem"}, {6'b0, rem_o}, 8'd0);
    chk({tag, " done"}, {7'b0, done_o}, 8'd0);
    chk({tag, " q"}, {7'b0, q_o}, 8'd0);
    chk({tag, " div"}, {7'b0, div_o}, 8'd1);
  endtask

  // Called at a negedge where the block is expected ready; returns at the done_o cycle's negedge.
  task automatic run_word(input logic [W-1:0] d, input bit keep_valid,
                          output logic [W-1:0] xs, output logic [W-1:0] qs, output logic [W-1:0] dvs);
    logic [W-1:0] qw;
    int pre;
    qw = d / 3;
    chk("ready before accept", {7'b0, ready_o}, 8'd1);
    data_i = d;
    valid_i = 1;
    @(posedge clk); @(negedge clk);
    if (!keep_valid) valid_i = 0;
    for (int i = 0; i < W; i++) begin
      data_i = W'($urandom);
      pre = int'(d >> (W - 1 - i));
      xs[W-1-i] = x_o;
      qs[W-1-i] = q_o;
      dvs[W-1-i] = div_o;
      chk("x_valid", {7'b0, x_valid_o}, 8'd1);
      chk("x bit", {7'b0, x_o}, {7'b0, d[W-1-i]});
      chk("q bit", {7'b0, q_o}, {7'b0, qw[W-1-i]});
      chk("div bit", {7'b0, div_o}, {7'b0, pre % 3 == 0});
      chk("last", {7'b0, last_o}, {7'b0, i == W - 1});
      chk("ready busy", {7'b0, ready_o}, 8'd0);
      chk("done early", {7'b0, done_o}, 8'd0);
      @(posedge clk); @(negedge clk);
    end
    chk("done pulse", {7'b0, done_o}, 8'd1);
    chk("rem", {6'b0, rem_o}, 8'(d % 3));
    chk("ready after", {7'b0, ready_o}, 8'd1);
    chk("x_valid idle", {7'b0, x_valid_o}, 8'd0);
  endtask

  initial begin
    vec_t tbl[4];
    logic [W-1:0] xs, qs, dvs;
    tbl[0] = '{8'd6,   8'b00000110, 8'b00000010, 8'b11111011, 2'd0};
    tbl[1] = '{8'd200, 8'b11001000, 8'b01000010, 8'b01110000, 2'd2};
    tbl[2] = '{8'hFF,  8'hFF,       8'b01010101, 8'b01010101, 2'd0};
    tbl[3] = '{8'h00,  8'h00,       8'h00,       8'hFF,       2'd0};
    @(negedge clk);
    reset_outputs("in reset");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset_outputs("after release");
    for (int k = 0; k < 4; k++) begin
      run_word(tbl[k].d, 0, xs, qs, dvs);
      chk("tbl x", xs, tbl[k].x);
      chk("tbl q", qs, tbl[k].q);
      chk("tbl div", dvs, tbl[k].dv);
      chk("tbl rem", {6'b0, rem_o}, {6'b0, tbl[k].rem});
    end
    // back-to-back with valid held high through both words
    run_word(8'd7, 1, xs, qs, dvs);
    chk("b2b rem1", {6'b0, rem_o}, 8'd1);
    run_word(8'd9, 1, xs, qs, dvs);
    chk("b2b x2", xs, 8'd9);
    chk("b2b rem2", {6'b0, rem_o}, 8'd0);
    valid_i = 0;
    @(negedge clk);
    chk("done one cycle", {7'b0, done_o}, 8'd0);
    chk("rem held", {6'b0, rem_o}, 8'd0);
    // reset mid-word on the 4th bit of 200
    data_i = 8'd200;
    valid_i = 1;
    @(posedge clk); @(negedge clk);
    valid_i = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("4th bit x", {7'b0, x_o}, 8'd0);
    chk("4th bit x_valid", {7'b0, x_valid_o}, 8'd1);
    reset = 0;
    #1;
    reset_outputs("async reset");
    @(posedge clk); @(negedge clk);
    reset_outputs("held reset");
    reset = 1;
    @(negedge clk);
    reset_outputs("no done after abort");
    run_word(8'd5, 0, xs, qs, dvs);
    chk("post-reset q", qs, 8'b00000001);
    chk("post-reset rem", {6'b0, rem_o}, 8'd2);
    // random words, some back-to-back
    for (int k = 0; k < 120; k++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      run_word(d, 0, xs, qs, dvs);
      chk("rand q word", qs, d / 3);
      chk("rand x word", xs, d);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
